// File: rtl/program_sequencer.sv
// Program counter unit for the fetch stage: owns the PC, handles jump/branch/call/ret,
// keeps a return-address stack, and tracks RUN / HALTED / FAULT state.
module program_sequencer #(
  parameter int unsigned     WIDTH      = 16,
  parameter int unsigned     STEP       = 2,
  parameter int unsigned     DEPTH      = 4,
  parameter int unsigned     BRANCH_REL = 0,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                         d,
  input  logic                         reset,
  input  logic                         halt,
  input  logic                         resume,
  input  logic                         jump,
  input  logic                         branch,
  input  logic                         call,
  input  logic                         ret,
  input  logic [WIDTH-1:0]             imm_jump,
  input  logic [WIDTH-1:0]             imm_branch,
  output logic [WIDTH-1:0]             pc,
  output logic                         halted,
  output logic                         fault,
  output logic [1:0]                   fault_code,
  output logic [$clog2(DEPTH+1)-1:0]   sp_count
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  localparam logic [1:0] CODE_NONE      = 2'b00;
  localparam logic [1:0] CODE_OVERFLOW  = 2'b01;
  localparam logic [1:0] CODE_UNDERFLOW = 2'b10;

  logic [1:0]       state, state_next;
  logic [WIDTH-1:0] pc_next;
  logic [SPW-1:0]   sp_next;
  logic [1:0]       code_next;
  logic             push;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] stack_top;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] branch_target;

  assign pc_seq        = pc + WIDTH'(STEP);
  assign branch_target = (BRANCH_REL != 0) ? pc + imm_branch : imm_branch;

  // Entry at index sp_count-1 is the most recent return address.
  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sp_count == SPW'(i + 1)) stack_top = stack[i];
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    sp_next    = sp_count;
    code_next  = fault_code;
    push       = 1'b0;
    case (state)
      ST_RUN: begin
        if (halt) begin
          state_next = ST_HALTED;
        end else if (jump) begin
          pc_next = imm_jump;
        end else if (call) begin
          if (sp_count < SPW'(DEPTH)) begin
            push    = 1'b1;
            sp_next = sp_count + SPW'(1);
            pc_next = imm_jump;
          end else begin
            state_next = ST_FAULT;
            code_next  = CODE_OVERFLOW;
          end
        end else if (ret) begin
          if (sp_count != '0) begin
            pc_next = stack_top;
            sp_next = sp_count - SPW'(1);
          end else begin
            state_next = ST_FAULT;
            code_next  = CODE_UNDERFLOW;
          end
        end else if (branch) begin
          pc_next = branch_target;
        end else begin
          pc_next = pc_seq;
        end
      end
      ST_HALTED: begin
        if (resume && !halt) state_next = ST_RUN;
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_FAULT;
      end
    endcase
  end

  always_ff @(posedge d) begin
    if (reset) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      sp_count   <= '0;
      fault_code <= CODE_NONE;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      sp_count   <= sp_next;
      fault_code <= code_next;
    end
  end

  // Stack contents need no reset; sp_count alone defines which entries are valid.
  always_ff @(posedge d) begin
    if (push && !reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (sp_count == SPW'(i)) stack[i] <= pc_seq;
      end
    end
  end

  assign halted = (state == ST_HALTED);
  assign fault  = (state == ST_FAULT);

endmodule
